// File: rtl/conn_pkg.sv
// conn_pkg: shared command/state encodings for the connection request arbiter.
package conn_pkg;
    localparam int DEF_NUM_CLIENTS = 4;

    typedef enum logic [1:0] {
        CMD_IDLE = 2'b00,
        CMD_CONN = 2'b01,
        CMD_DISC = 2'b10
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        SETTLE
    } arb_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from ptr with wraparound.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic                 any_req,
    output logic [$clog2(N)-1:0] grant
);
    localparam int IW = $clog2(N);

    logic [IW-1:0] k;

    assign any_req = |req;

    // Scan from the farthest offset down so the nearest request to ptr wins last.
    always_comb begin
        grant = '0;
        k     = '0;
        for (int i = N - 1; i >= 0; i--) begin
            k = IW'((int'(ptr) + i) % N);
            if (req[k]) grant = k;
        end
    end
endmodule

// File: rtl/conn_req_arbiter.sv
// conn_req_arbiter: serialises client connect/disconnect requests into the server command stream.
// WAIT_TIMEOUT_EN drops connects that stay blocked by srv_full for TIMEOUT_CYCLES idle cycles.
module conn_req_arbiter
    import conn_pkg::*;
#(
    parameter int NUM_CLIENTS    = DEF_NUM_CLIENTS,
    parameter int TIMEOUT_CYCLES = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_CLIENTS-1:0]         req_conn,
    input  logic [NUM_CLIENTS-1:0]         req_disc,
    input  logic                           srv_full,
    output logic [1:0]                     cmd,
    output logic                           grant_valid,
    output logic [$clog2(NUM_CLIENTS)-1:0] grant_id,
    output logic                           grant_is_disc,
    output logic [NUM_CLIENTS-1:0]         connected,
    output logic                           busy,
    output logic                           reject_valid,
    output logic [$clog2(NUM_CLIENTS)-1:0] reject_id
);
    localparam int N  = NUM_CLIENTS;
    localparam int IW = $clog2(N);

    typedef logic [N-1:0]  vec_t;
    typedef logic [IW-1:0] id_t;

    arb_state_t state, state_n;
    cmd_t       cmd_q, cmd_n;
    vec_t       pend_conn, pend_disc, pend_conn_n, pend_disc_n, connected_n;
    vec_t       set_conn, set_disc, cancel;
    id_t        ptr_conn, ptr_disc, ptr_conn_n, ptr_disc_n, g_conn, g_disc, grant_id_n;
    logic       any_conn, any_disc, grant_valid_n, grant_is_disc_n;

    function automatic id_t nxt(input id_t g);
        return (g == id_t'(N - 1)) ? '0 : g + 1'b1;
    endfunction

    rr_arbiter #(.N(N)) u_disc (
        .req    (pend_disc),
        .ptr    (ptr_disc),
        .any_req(any_disc),
        .grant  (g_disc)
    );

    rr_arbiter #(.N(N)) u_conn (
        .req    (pend_conn),
        .ptr    (ptr_conn),
        .any_req(any_conn),
        .grant  (g_conn)
    );

    // A simultaneous conn+disc on an unconnected client keeps the connect, so no cancel then.
    assign set_conn = req_conn & ~connected & ~pend_conn;
    assign set_disc = req_disc & connected;
    assign cancel   = req_disc & ~req_conn & ~connected;
    assign cmd      = cmd_q;
    assign busy     = (state != IDLE) | (|pend_conn) | (|pend_disc);

`ifdef WAIT_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt, cnt_n;
    logic          reject_valid_n;
    id_t           reject_id_n;
    logic          blocked;

    assign blocked = (state == IDLE) && any_conn && srv_full && !any_disc;
`else
    logic unused_timeout;

    assign reject_valid   = 1'b0;
    assign reject_id      = '0;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_n         = state;
        cmd_n           = CMD_IDLE;
        grant_valid_n   = 1'b0;
        grant_id_n      = grant_id;
        grant_is_disc_n = grant_is_disc;
        pend_conn_n     = (pend_conn & ~cancel) | set_conn;
        pend_disc_n     = pend_disc | set_disc;
        connected_n     = connected;
        ptr_conn_n      = ptr_conn;
        ptr_disc_n      = ptr_disc;
`ifdef WAIT_TIMEOUT_EN
        cnt_n          = '0;
        reject_valid_n = 1'b0;
        reject_id_n    = reject_id;
        if (blocked) begin
            if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                pend_conn_n[g_conn] = 1'b0;
                reject_valid_n      = 1'b1;
                reject_id_n         = g_conn;
                ptr_conn_n          = nxt(g_conn);
            end else begin
                cnt_n = cnt + 1'b1;
            end
        end
`endif
        case (state)
            IDLE: begin
                if (any_disc) begin
                    state_n         = ISSUE;
                    cmd_n           = CMD_DISC;
                    grant_valid_n   = 1'b1;
                    grant_id_n      = g_disc;
                    grant_is_disc_n = 1'b1;
                    ptr_disc_n      = nxt(g_disc);
                end else if (any_conn && !srv_full) begin
                    state_n         = ISSUE;
                    cmd_n           = CMD_CONN;
                    grant_valid_n   = 1'b1;
                    grant_id_n      = g_conn;
                    grant_is_disc_n = 1'b0;
                    ptr_conn_n      = nxt(g_conn);
                end
            end
            ISSUE: begin
                state_n = SETTLE;
                if (grant_is_disc) begin
                    pend_disc_n[grant_id] = 1'b0;
                    connected_n[grant_id] = 1'b0;
                end else begin
                    pend_conn_n[grant_id] = 1'b0;
                    connected_n[grant_id] = 1'b1;
                end
            end
            SETTLE:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cmd_q         <= CMD_IDLE;
            grant_valid   <= 1'b0;
            grant_id      <= '0;
            grant_is_disc <= 1'b0;
            pend_conn     <= '0;
            pend_disc     <= '0;
            connected     <= '0;
            ptr_conn      <= '0;
            ptr_disc      <= '0;
`ifdef WAIT_TIMEOUT_EN
            cnt           <= '0;
            reject_valid  <= 1'b0;
            reject_id     <= '0;
`endif
        end else begin
            state         <= state_n;
            cmd_q         <= cmd_n;
            grant_valid   <= grant_valid_n;
            grant_id      <= grant_id_n;
            grant_is_disc <= grant_is_disc_n;
            pend_conn     <= pend_conn_n;
            pend_disc     <= pend_disc_n;
            connected     <= connected_n;
            ptr_conn      <= ptr_conn_n;
            ptr_disc      <= ptr_disc_n;
`ifdef WAIT_TIMEOUT_EN
            cnt           <= cnt_n;
            reject_valid  <= reject_valid_n;
            reject_id     <= reject_id_n;
`endif
        end
    end
endmodule

// File: tb/tb_conn_req_arbiter.sv
// tb_conn_req_arbiter: directed scoreboard bench; stimulus queues expected grants/rejects, a monitor pops them.
module tb_conn_req_arbiter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       srv_full = 1'b0;
    logic [3:0] req_conn = '0;
    logic [3:0] req_disc = '0;
    logic [1:0] cmd;
    logic       grant_valid, grant_is_disc, busy, reject_valid;
    logic [1:0] grant_id, reject_id;
    logic [3:0] connected;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        logic       disc;
        logic [1:0] id;
        int         cyc;
    } ev_t;

    ev_t gq[$];
    ev_t rq[$];
    ev_t ge, re;

`ifdef WAIT_TIMEOUT_EN
    localparam int BLOCK = 5;
`else
    localparam int BLOCK = 20;
`endif

    conn_req_arbiter #(.NUM_CLIENTS(4), .TIMEOUT_CYCLES(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_conn     (req_conn),
        .req_disc     (req_disc),
        .srv_full     (srv_full),
        .cmd          (cmd),
        .grant_valid  (grant_valid),
        .grant_id     (grant_id),
        .grant_is_disc(grant_is_disc),
        .connected    (connected),
        .busy         (busy),
        .reject_valid (reject_valid),
        .reject_id    (reject_id)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [3:0] c, input logic [3:0] d);
        req_conn = c;
        req_disc = d;
        step();
        req_conn = '0;
        req_disc = '0;
    endtask

    task automatic expg(input logic disc, input logic [1:0] id, input int dly);
        gq.push_back('{disc, id, cyc + dly});
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (grant_valid) begin
                if (gq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_grant: got id=%0d disc=%0d at cycle %0d, want none", grant_id, grant_is_disc, cyc);
                end else begin
                    ge = gq.pop_front();
                    chk("grant_cmd", cmd, ge.disc ? 2 : 1);
                    chk("grant_id", grant_id, ge.id);
                    chk("grant_is_disc", grant_is_disc, ge.disc);
                    chk("grant_cycle", cyc, ge.cyc);
                end
            end else begin
                chk("cmd_idle", cmd, 0);
            end
            if (reject_valid) begin
                if (rq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_reject: got id=%0d at cycle %0d, want none", reject_id, cyc);
                end else begin
                    re = rq.pop_front();
                    chk("reject_id", reject_id, re.id);
                    chk("reject_cycle", cyc, re.cyc);
                end
            end
        end
    end

    initial begin
        step(3);
        chk("rst_cmd", cmd, 0);
        chk("rst_gv", grant_valid, 0);
        chk("rst_gid", grant_id, 0);
        chk("rst_gdisc", grant_is_disc, 0);
        chk("rst_conn", connected, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rej", reject_valid, 0);
        rst_n = 1'b1;
        step(2);
        chk("idle_busy", busy, 0);

        // single connect
        pulse(4'b0100, 4'b0000);
        expg(0, 2, 1);
        chk("single_busy", busy, 1);
        step(2);
        chk("single_conn", connected, 4'b0100);
        chk("single_settle_cmd", cmd, 0);
        step(2);

        // reset while issuing a connect
        pulse(4'b0001, 4'b0000);
        step();
        chk("issue_cmd", cmd, 1);
        chk("issue_gv", grant_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_cmd", cmd, 0);
        chk("midrst_conn", connected, 0);
        chk("midrst_gv", grant_valid, 0);
        chk("midrst_busy", busy, 0);
        step(2);
        rst_n = 1'b1;
        step(5);
        chk("postrst_busy", busy, 0);

        // priority and round robin
        pulse(4'b1000, 4'b0000);
        expg(0, 3, 1);
        step(4);
        chk("setup_conn", connected, 4'b1000);
        pulse(4'b0011, 4'b1000);
        expg(1, 3, 1);
        expg(0, 0, 4);
        expg(0, 1, 7);
        step(9);
        chk("prio_conn", connected, 4'b0011);
        chk("prio_busy", busy, 0);

        // full blocking
        pulse(4'b0100, 4'b0000);
        expg(0, 2, 1);
        step(4);
        chk("full_setup", connected, 4'b0111);
        srv_full = 1'b1;
        pulse(4'b1000, 4'b0000);
        step(BLOCK);
        chk("full_busy", busy, 1);
        chk("full_conn", connected, 4'b0111);
        pulse(4'b0000, 4'b0001);
        expg(1, 0, 1);
        srv_full = 1'b0;
        expg(0, 3, 4);
        step(6);
        chk("full_final", connected, 4'b1110);

        // illegal requests and cancel
        pulse(4'b0010, 4'b0001);
        chk("illegal_busy0", busy, 0);
        step(3);
        chk("illegal_busy1", busy, 0);
        srv_full = 1'b1;
        pulse(4'b0001, 4'b0000);
        chk("cancel_pend", busy, 1);
        pulse(4'b0000, 4'b0001);
        chk("cancel_busy", busy, 0);
        srv_full = 1'b0;
        step(5);
        chk("cancel_conn", connected, 4'b1110);

        // conn+disc together
        pulse(4'b0001, 4'b0001);
        expg(0, 0, 1);
        step(4);
        pulse(4'b0010, 4'b0010);
        expg(1, 1, 1);
        step(4);
        chk("both_conn", connected, 4'b1101);

        // round robin wrap
        pulse(4'b0000, 4'b1101);
        expg(1, 2, 1);
        expg(1, 3, 4);
        expg(1, 0, 7);
        step(9);
        chk("rr_disc_conn", connected, 4'b0000);
        pulse(4'b1111, 4'b0000);
        expg(0, 1, 1);
        expg(0, 2, 4);
        expg(0, 3, 7);
        expg(0, 0, 10);
        step(12);
        chk("rr_conn_conn", connected, 4'b1111);

        // blocked connect timeout
        pulse(4'b0000, 4'b0001);
        expg(1, 0, 1);
        step(4);
        srv_full = 1'b1;
        pulse(4'b0001, 4'b0000);
`ifdef WAIT_TIMEOUT_EN
        rq.push_back('{1'b0, 2'd0, cyc + 8});
        step(10);
        chk("timeout_busy", busy, 0);
        srv_full = 1'b0;
        step(4);
        chk("timeout_conn", connected, 4'b1110);
`else
        step(100);
        chk("wait_busy", busy, 1);
        srv_full = 1'b0;
        expg(0, 0, 1);
        step(4);
        chk("wait_conn", connected, 4'b1111);
`endif

        step(2);
        chk("grants_left", gq.size(), 0);
        chk("rejects_left", rq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
